// File: rtl/conv_input_loader_pkg.sv
// Shared types and constants for the convolution input loader.
package conv_input_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FILT,
    LOAD_PIC,
    START,
    WAIT_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_input_loader_if.sv
// Byte-stream input and word-write memory bus of the convolution input loader.
interface conv_input_loader_if
  import conv_input_loader_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/conv_input_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words with a one-cycle word_valid pulse.
module conv_input_loader_byte_packer
  import conv_input_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_take,
  input  logic [7:0]        byte_data,
  input  logic              flush,
  output logic [1:0]        byte_cnt,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [23:0] partial;

  // flush wins over a simultaneous byte so a discarded word never reaches memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      partial    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (flush) begin
        byte_cnt <= '0;
      end else if (byte_take) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    partial[7:0]   <= byte_data;
          2'd1:    partial[15:8]  <= byte_data;
          2'd2:    partial[23:16] <= byte_data;
          default: begin
            word       <= {byte_data, partial};
            word_valid <= 1'b1;
          end
        endcase
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/conv_input_loader.sv
// Loads filters then picture words into accelerator memory, then starts it and waits for done.
module conv_input_loader
  import conv_input_loader_pkg::*;
#(
  parameter int CONV_NUM     = 2,
  parameter int FILTER_WORDS = 4,
  parameter int PIC_WORDS    = 64,
  parameter int ADDR_W       = 8,
  parameter int FILTER_BASE  = 0,
  parameter int PIC_BASE     = 128
) (
  input  logic                clk,
  input  logic                rst,
  conv_input_loader_if.master bus,
  input  logic                load_req,
  output logic                start_everything,
  input  logic                accel_done,
  output logic                busy,
  output logic                err_len
);

  localparam int FILT_TOTAL = CONV_NUM * FILTER_WORDS;
  localparam int WCNT_W     = $clog2(max_int(FILT_TOTAL, PIC_WORDS)) + 1;

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              prev_done;
  logic [1:0]        byte_cnt;
  logic              take;
  logic              word_end;
  logic              stream_final;
  logic              early_last;
  logic              flush;

  assign bus.in_ready = (state == LOAD_FILT) || (state == LOAD_PIC);
  assign busy         = (state != IDLE);

  assign take         = bus.in_valid && bus.in_ready;
  assign word_end     = take && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign stream_final = word_end && (state == LOAD_PIC) && (wcnt == WCNT_W'(PIC_WORDS - 1));
  assign early_last   = take && bus.in_last && !stream_final;
  assign flush        = (state == IDLE) || early_last;

  conv_input_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_take  (take),
    .byte_data  (bus.in_data),
    .flush      (flush),
    .byte_cnt   (byte_cnt),
    .word_valid (bus.mem_we),
    .word       (bus.mem_wdata)
  );

  // Address is latched with the completing byte so it lines up with the packer's write pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wcnt             <= '0;
      bus.mem_addr     <= '0;
      start_everything <= 1'b0;
      err_len          <= 1'b0;
      prev_done        <= 1'b0;
    end else begin
      start_everything <= 1'b0;
      prev_done        <= accel_done;
      case (state)
        IDLE: begin
          if (load_req) begin
            err_len <= 1'b0;
            wcnt    <= '0;
            state   <= LOAD_FILT;
          end
        end
        LOAD_FILT: begin
          if (early_last) begin
            err_len <= 1'b1;
            state   <= IDLE;
          end else if (word_end) begin
            bus.mem_addr <= ADDR_W'(FILTER_BASE) + ADDR_W'(wcnt);
            if (wcnt == WCNT_W'(FILT_TOTAL - 1)) begin
              wcnt  <= '0;
              state <= LOAD_PIC;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        LOAD_PIC: begin
          if (early_last) begin
            err_len <= 1'b1;
            state   <= IDLE;
          end else if (word_end) begin
            bus.mem_addr <= ADDR_W'(PIC_BASE) + ADDR_W'(wcnt);
            if (stream_final) begin
              wcnt <= '0;
              if (bus.in_last) begin
                state <= START;
              end else begin
                err_len <= 1'b1;
                state   <= IDLE;
              end
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        START: begin
          start_everything <= 1'b1;
          state            <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // only a fresh rising edge counts; a done level left over from an earlier run is ignored
          if (accel_done && !prev_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_input_loader.sv
// Scoreboard bench for conv_input_loader: random byte streams against a word-level reference model.
module tb_conv_input_loader;

  localparam int CONV_NUM     = 2;
  localparam int FILTER_WORDS = 2;
  localparam int PIC_WORDS    = 3;
  localparam int ADDR_W       = 8;
  localparam int FILTER_BASE  = 0;
  localparam int PIC_BASE     = 16;
  localparam int FILT_TOTAL   = CONV_NUM * FILTER_WORDS;
  localparam int TOTAL_WORDS  = FILT_TOTAL + PIC_WORDS;
  localparam int TOTAL_BYTES  = TOTAL_WORDS * 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic load_req;
  logic start_everything;
  logic accel_done;
  logic busy;
  logic err_len;

  conv_input_loader_if #(.ADDR_W(ADDR_W)) bus ();

  conv_input_loader #(
    .CONV_NUM     (CONV_NUM),
    .FILTER_WORDS (FILTER_WORDS),
    .PIC_WORDS    (PIC_WORDS),
    .ADDR_W       (ADDR_W),
    .FILTER_BASE  (FILTER_BASE),
    .PIC_BASE     (PIC_BASE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .load_req         (load_req),
    .start_everything (start_everything),
    .accel_done       (accel_done),
    .busy             (busy),
    .err_len          (err_len)
  );

  always #5 clk = ~clk;

  int        total = 0;
  int        bad = 0;
  int        cyc = 0;
  int        last_wr = -100;
  int        start_seen = 0;
  wr_t       exp_q[$];
  logic [7:0] stream[TOTAL_BYTES];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: words fully received before the stream ends are written in order
  task automatic pushExpected(input int nwords);
    wr_t e;
    for (int w = 0; w < nwords; w++) begin
      if (w < FILT_TOTAL) e.addr = ADDR_W'((FILTER_BASE + w) % (1 << ADDR_W));
      else                e.addr = ADDR_W'((PIC_BASE + w - FILT_TOTAL) % (1 << ADDR_W));
      e.data = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (bus.mem_we) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", {24'd0, bus.mem_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          checkOutput("wr_addr", {24'd0, bus.mem_addr}, {24'd0, e.addr});
          checkOutput("wr_data", bus.mem_wdata, e.data);
        end
        last_wr = cyc;
      end
      if (start_everything) begin
        start_seen++;
        checkOutput("start_after_write", cyc - last_wr, 1);
      end
    end
  end

  task automatic pulseLoad();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic sendStream(input int nbytes, input int early_pos, input bit final_last, input bit gaps);
    int i = 0;
    int budget = 0;
    while (i < nbytes && budget < 1000) begin
      @(negedge clk);
      budget++;
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = stream[i];
      bus.in_last  = (i == early_pos) || (i == TOTAL_BYTES - 1 && final_last);
      if (bus.in_valid && bus.in_ready) i++;
    end
    if (i < nbytes) checkOutput("stream_budget", i, nbytes);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic applyStimulus(input int early_pos, input bit final_last, input bit gaps);
    int  nbytes;
    int  starts0;
    bit  exp_err;
    nbytes  = (early_pos >= 0) ? early_pos + 1 : TOTAL_BYTES;
    exp_err = (early_pos >= 0) || !final_last;
    starts0 = start_seen;
    pushExpected((early_pos >= 0) ? early_pos / 4 : TOTAL_WORDS);
    pulseLoad();
    sendStream(nbytes, early_pos, final_last, gaps);
    checkOutput("ready_low_after_end", bus.in_ready, 0);
    repeat (6) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("err_len", err_len, exp_err);
    checkOutput("start_count", start_seen - starts0, exp_err ? 0 : 1);
    checkOutput("busy_after_load", busy, exp_err ? 0 : 1);
    exp_q.delete();
  endtask

  task automatic finishRun();
    @(negedge clk);
    accel_done = 1'b1;
    @(negedge clk);
    checkOutput("busy_after_done", busy, 0);
    accel_done = 1'b0;
  endtask

  task automatic fillStream(input bit random_data);
    for (int i = 0; i < TOTAL_BYTES; i++) stream[i] = random_data ? 8'($urandom) : 8'(i);
  endtask

  initial begin
    rst          = 1'b1;
    load_req     = 1'b0;
    accel_done   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_mem_addr", {24'd0, bus.mem_addr}, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_start", start_everything, 0);
    checkOutput("rst_err_len", err_len, 0);
    rst = 1'b0;

    $display("[TB] nominal load with stale done level");
    fillStream(1'b0);
    accel_done = 1'b1;
    applyStimulus(-1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("busy_done_level_held", busy, 1);
    load_req = 1'b1;
    @(negedge clk);
    load_req   = 1'b0;
    accel_done = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("busy_done_low", busy, 1);
    accel_done = 1'b1;
    checkOutput("busy_before_edge", busy, 1);
    @(negedge clk);
    checkOutput("busy_after_edge", busy, 0);
    @(negedge clk);
    checkOutput("load_req_ignored", busy, 0);
    accel_done = 1'b0;

    $display("[TB] backpressure gaps");
    fillStream(1'b1);
    applyStimulus(-1, 1'b1, 1'b1);
    finishRun();

    $display("[TB] early in_last then recovery");
    fillStream(1'b0);
    applyStimulus(9, 1'b1, 1'b0);
    pulseLoad();
    checkOutput("err_cleared", err_len, 0);
    checkOutput("busy_new_load", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] missing in_last");
    fillStream(1'b1);
    applyStimulus(-1, 1'b0, 1'b1);

    $display("[TB] reset mid-load");
    fillStream(1'b1);
    pushExpected(1);
    pulseLoad();
    sendStream(7, -1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_mem_we", bus.mem_we, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_in_ready", bus.in_ready, 0);
    checkOutput("midrst_start", start_everything, 0);
    checkOutput("midrst_queue", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    fillStream(1'b1);
    applyStimulus(-1, 1'b1, 1'b1);
    finishRun();

    $display("[TB] random streams");
    for (int r = 0; r < 4; r++) begin
      int early;
      bit fl;
      early = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TOTAL_BYTES - 1)) : -1;
      fl    = ($urandom_range(0, 3) != 0);
      if (early == TOTAL_BYTES - 1) begin
        early = -1;
        fl    = 1'b1;
      end
      fillStream(1'b1);
      applyStimulus(early, fl, 1'b1);
      if (early < 0 && fl) finishRun();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
